// File: rtl/tsb_retry_sched_pkg.sv
// Shared types and constants for the TSB retry scheduler.
package tsb_retry_sched_pkg;

  localparam int unsigned LOG_TSB_SIZE           = 6;
  localparam int unsigned CYC_W                  = 16;
  localparam int unsigned ATT_W                  = 4;
  localparam int unsigned TSB_RETRY_BACKOFF_BASE = 16;
  localparam int unsigned TSB_RETRY_MAX_SHIFT    = 6;

  typedef logic [LOG_TSB_SIZE-1:0] tsb_entry_id_t;

  typedef struct packed {
    tsb_entry_id_t    id;
    logic             tied;
    logic             abort;
    logic [CYC_W-1:0] due;
  } retry_req_t;

endpackage

// File: rtl/tsb_retry_sched_fifo.sv
// Synchronous FIFO of pending retry requests; push and pop may share a cycle.
module tsb_retry_sched_fifo
  import tsb_retry_sched_pkg::*;
#(
  parameter int unsigned LOG_DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  retry_req_t i_data,
  input  logic       i_pop,
  output retry_req_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam int unsigned PTR_W = LOG_DEPTH + 1;

  retry_req_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[LOG_DEPTH-1:0] == r_rd_ptr[LOG_DEPTH-1:0]) &&
                     (r_wr_ptr[LOG_DEPTH] != r_rd_ptr[LOG_DEPTH]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[LOG_DEPTH-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[LOG_DEPTH-1:0]] <= i_data;
  end

endmodule

// File: rtl/tsb_retry_sched.sv
// Re-enqueue scheduler for NACKed TSB tasks: FIFO order with per-entry
// exponential backoff; aborts are due immediately.
module tsb_retry_sched
  import tsb_retry_sched_pkg::*;
#(
  parameter int unsigned LOG_Q_DEPTH  = 3,
  parameter int unsigned BACKOFF_BASE = TSB_RETRY_BACKOFF_BASE,
  parameter int unsigned MAX_SHIFT    = TSB_RETRY_MAX_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  input  logic [LOG_TSB_SIZE-1:0] alloc_tsb_id,
  input  logic                    nack_valid,
  output logic                    nack_ready,
  input  logic [LOG_TSB_SIZE-1:0] nack_tsb_id,
  input  logic                    nack_tied,
  input  logic                    nack_abort,
  output logic                    retry_valid,
  input  logic                    retry_ready,
  output logic [LOG_TSB_SIZE-1:0] retry_tsb_id,
  output logic                    retry_tied,
  output logic                    retry_abort,
  output logic                    empty,
  output logic [31:0]             n_retries
);

  localparam int unsigned         TSB_N     = 1 << LOG_TSB_SIZE;
  localparam logic [ATT_W-1:0]    ATT_MAX   = '1;
  localparam logic [ATT_W-1:0]    SHIFT_CAP = ATT_W'(MAX_SHIFT);

  logic [CYC_W-1:0]  r_now;
  logic [ATT_W-1:0]  r_attempts [TSB_N];
  logic              r_retry_valid;
  tsb_entry_id_t     r_retry_id;
  logic              r_retry_tied;
  logic              r_retry_abort;
  logic [31:0]       r_n_retries;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_hs;
  logic              w_head_due;
  retry_req_t        w_push_req;
  retry_req_t        w_head;
  logic [ATT_W-1:0]  w_att;
  logic [ATT_W-1:0]  w_shift;
  logic [CYC_W-1:0]  w_backoff;
  logic [CYC_W-1:0]  w_age;

  assign nack_ready = !w_fifo_full && !rst;
  assign w_push     = nack_valid && nack_ready;

  // Backoff grows with the entry's completed retries, exponent capped.
  assign w_att     = r_attempts[nack_tsb_id];
  assign w_shift   = (w_att > SHIFT_CAP) ? SHIFT_CAP : w_att;
  assign w_backoff = CYC_W'(BACKOFF_BASE) << w_shift;

  always_comb begin
    w_push_req       = '0;
    w_push_req.id    = nack_tsb_id;
    w_push_req.tied  = nack_tied;
    w_push_req.abort = nack_abort;
    w_push_req.due   = nack_abort ? r_now : (r_now + w_backoff);
  end

  tsb_retry_sched_fifo #(
    .LOG_DEPTH (LOG_Q_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Wrap-safe due test: sign bit of (now - due).
  assign w_age      = r_now - w_head.due;
  assign w_head_due = !w_fifo_empty && !w_age[CYC_W-1];
  assign w_hs       = r_retry_valid && retry_ready;
  assign w_pop      = w_head_due && (!r_retry_valid || retry_ready) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_now         <= '0;
      r_retry_valid <= 1'b0;
      r_retry_id    <= '0;
      r_retry_tied  <= 1'b0;
      r_retry_abort <= 1'b0;
      r_n_retries   <= '0;
    end else begin
      r_now <= r_now + CYC_W'(1);
      if (w_pop) begin
        r_retry_valid <= 1'b1;
        r_retry_id    <= w_head.id;
        r_retry_tied  <= w_head.tied;
        r_retry_abort <= w_head.abort;
      end else if (w_hs) begin
        r_retry_valid <= 1'b0;
      end
      if (w_hs && !r_retry_abort) r_n_retries <= r_n_retries + 32'd1;
    end
  end

  // Alloc clear is written last so it wins over a same-id increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(TSB_N); i++) r_attempts[i] <= '0;
    end else begin
      if (w_hs && !r_retry_abort && (r_attempts[r_retry_id] != ATT_MAX))
        r_attempts[r_retry_id] <= r_attempts[r_retry_id] + ATT_W'(1);
      if (alloc_valid) r_attempts[alloc_tsb_id] <= '0;
    end
  end

  assign retry_valid  = r_retry_valid;
  assign retry_tsb_id = r_retry_id;
  assign retry_tied   = r_retry_tied;
  assign retry_abort  = r_retry_abort;
  assign n_retries    = r_n_retries;
  assign empty        = rst || (w_fifo_empty && !r_retry_valid);

endmodule

// File: tb/tb_tsb_retry_sched.sv
// Scoreboard bench for tsb_retry_sched: issue order, backoff timing, aborts,
// full-FIFO flow control, counter wrap and mid-run reset.
module tb_tsb_retry_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [5:0]  alloc_tsb_id = '0;
  logic        nack_valid = 1'b0;
  logic        nack_ready;
  logic [5:0]  nack_tsb_id = '0;
  logic        nack_tied = 1'b0;
  logic        nack_abort = 1'b0;
  logic        retry_valid;
  logic        retry_ready = 1'b0;
  logic [5:0]  retry_tsb_id;
  logic        retry_tied;
  logic        retry_abort;
  logic        empty;
  logic [31:0] n_retries;

  always #5 clk = ~clk;

  tsb_retry_sched dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_tsb_id (alloc_tsb_id),
    .nack_valid   (nack_valid),
    .nack_ready   (nack_ready),
    .nack_tsb_id  (nack_tsb_id),
    .nack_tied    (nack_tied),
    .nack_abort   (nack_abort),
    .retry_valid  (retry_valid),
    .retry_ready  (retry_ready),
    .retry_tsb_id (retry_tsb_id),
    .retry_tied   (retry_tied),
    .retry_abort  (retry_abort),
    .empty        (empty),
    .n_retries    (n_retries)
  );

  typedef struct packed {
    logic [5:0] id;
    logic       tied;
    logic       abort;
  } sb_t;

  sb_t         exp_q[$];
  sb_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] tb_now = '0;

  // Cycle counter model: zero while reset is sampled, +1 otherwise.
  task automatic tick;
    @(posedge clk);
    if (rst) tb_now = 16'd0;
    else     tb_now = tb_now + 16'd1;
    #1;
  endtask

  // Handshake monitor: each accepted retry must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && retry_valid === 1'b1 && retry_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got id %0d tied %b abort %b, required no retry",
                 retry_tsb_id, retry_tied, retry_abort);
      end else begin
        mon_e = exp_q.pop_front();
        if ({retry_tsb_id, retry_tied, retry_abort} !== mon_e) begin
          errors++;
          $display("FAIL sb_payload: got id %0d tied %b abort %b, required id %0d tied %b abort %b",
                   retry_tsb_id, retry_tied, retry_abort, mon_e.id, mon_e.tied, mon_e.abort);
        end
      end
    end
  end

  task automatic wait_valid(input int budget, output logic [15:0] t);
    int n = 0;
    while (retry_valid !== 1'b1 && n < budget) begin
      tick;
      n++;
    end
    t = tb_now;
    if (retry_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: retry_valid %b after %0d cycles, required 1", retry_valid, budget);
    end
  endtask

  task automatic send_nack(input logic [5:0] id, input logic tied, input logic abort);
    nack_valid  = 1'b1;
    nack_tsb_id = id;
    nack_tied   = tied;
    nack_abort  = abort;
    checks++;
    if (nack_ready !== 1'b1) begin
      errors++;
      $display("FAIL nack_ready: got %b, required 1 (id %0d)", nack_ready, id);
    end
    exp_q.push_back({id, tied, abort});
    tick;
    nack_valid = 1'b0;
  endtask

  task automatic do_alloc(input logic [5:0] id);
    alloc_valid  = 1'b1;
    alloc_tsb_id = id;
    tick;
    alloc_valid  = 1'b0;
  endtask

  // One non-abort retry: checks rise time = accept time + delay + 1.
  task automatic do_retry(input logic [5:0] id, input int delay);
    logic [15:0] t0, t, want;
    t0   = tb_now;
    want = t0 + 16'(delay) + 16'd1;
    send_nack(id, 1'b0, 1'b0);
    wait_valid(delay + 20, t);
    checks++;
    if (t !== want) begin
      errors++;
      $display("FAIL retry_time id %0d: rise at now %0d, required %0d", id, t, want);
    end
    retry_ready = 1'b1;
    tick;
    retry_ready = 1'b0;
    checks++;
    if (retry_valid !== 1'b0) begin
      errors++;
      $display("FAIL retry_drop id %0d: retry_valid %b, required 0", id, retry_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({retry_valid, empty, nack_ready, retry_tsb_id, retry_tied, retry_abort} !== {1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: valid %b empty %b nack_ready %b id %0d tied %b abort %b, required 0 1 0 0 0 0",
               retry_valid, empty, nack_ready, retry_tsb_id, retry_tied, retry_abort);
    end
    checks++;
    if (n_retries !== 32'd0) begin
      errors++;
      $display("FAIL reset_n_retries: got %0d, required 0", n_retries);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_retry;
    logic [15:0] t;
    do_alloc(6'd5);
    while (tb_now != 16'd100) tick;
    send_nack(6'd5, 1'b1, 1'b0);
    wait_valid(40, t);
    checks++;
    if (t !== 16'd117) begin
      errors++;
      $display("FAIL first_rise: rise at now %0d, required 117", t);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({retry_valid, retry_tsb_id, retry_tied, retry_abort} !== {1'b1, 6'd5, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL hold_stable: valid %b id %0d tied %b abort %b, required 1 5 1 0",
                 retry_valid, retry_tsb_id, retry_tied, retry_abort);
      end
    end
    retry_ready = 1'b1;
    tick;
    retry_ready = 1'b0;
    checks++;
    if (n_retries !== 32'd1 || retry_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_handshake: n_retries %0d valid %b, required 1 0", n_retries, retry_valid);
    end
  endtask

  task automatic test_backoff;
    for (int k = 1; k <= 7; k++) do_retry(6'd5, 16 << ((k > 6) ? 6 : k));
    checks++;
    if (n_retries !== 32'd8) begin
      errors++;
      $display("FAIL backoff_count: n_retries %0d, required 8", n_retries);
    end
    do_retry(6'd5, 1024);
  endtask

  task automatic test_abort;
    logic [15:0] t0, t;
    t0 = tb_now;
    send_nack(6'd9, 1'b1, 1'b1);
    wait_valid(10, t);
    checks++;
    if (t !== t0 + 16'd2 || retry_abort !== 1'b1) begin
      errors++;
      $display("FAIL abort_latency: rise at %0d abort %b, required %0d 1", t, retry_abort, t0 + 16'd2);
    end
    retry_ready = 1'b1;
    tick;
    retry_ready = 1'b0;
    checks++;
    if (n_retries !== 32'd9) begin
      errors++;
      $display("FAIL abort_count: n_retries %0d, required 9", n_retries);
    end
    do_retry(6'd9, 16);
  endtask

  task automatic test_alloc_clear;
    logic [15:0] t0, t;
    do_alloc(6'd5);
    do_retry(6'd5, 16);
    t0 = tb_now;
    send_nack(6'd5, 1'b0, 1'b0);
    wait_valid(60, t);
    checks++;
    if (t !== t0 + 16'd33) begin
      errors++;
      $display("FAIL second_delay: rise at %0d, required %0d", t, t0 + 16'd33);
    end
    retry_ready  = 1'b1;
    alloc_valid  = 1'b1;
    alloc_tsb_id = 6'd5;
    tick;
    retry_ready  = 1'b0;
    alloc_valid  = 1'b0;
    do_retry(6'd5, 16);
    checks++;
    if (n_retries !== 32'd13) begin
      errors++;
      $display("FAIL alloc_count: n_retries %0d, required 13", n_retries);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] t;
    int n = 0;
    for (int i = 0; i < 8; i++) send_nack(6'(10 + i), 1'b0, 1'b0);
    nack_valid  = 1'b1;
    nack_tsb_id = 6'd18;
    nack_tied   = 1'b1;
    nack_abort  = 1'b0;
    while (retry_valid !== 1'b1 && n < 40) begin
      checks++;
      if (nack_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_ready: nack_ready %b at now %0d, required 0", nack_ready, tb_now);
      end
      tick;
      n++;
    end
    checks++;
    if (nack_ready !== 1'b1 || retry_valid !== 1'b1) begin
      errors++;
      $display("FAIL pop_frees: nack_ready %b valid %b, required 1 1", nack_ready, retry_valid);
    end
    exp_q.push_back({6'd18, 1'b1, 1'b0});
    tick;
    nack_valid  = 1'b0;
    retry_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (retry_valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back slot %0d: retry_valid %b, required 1", i, retry_valid);
      end
      tick;
    end
    wait_valid(40, t);
    tick;
    retry_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL drain: %0d pending, empty %b, required 0 pending empty 1", exp_q.size(), empty);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] t;
    while (tb_now != 16'hFFF8) tick;
    send_nack(6'd20, 1'b0, 1'b0);
    wait_valid(40, t);
    checks++;
    if (t !== 16'h0009) begin
      errors++;
      $display("FAIL wrap_rise: rise at now %h, required 0009", t);
    end
    retry_ready = 1'b1;
    tick;
    retry_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    send_nack(6'd30, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_nack(6'(31 + i), 1'b0, 1'b0);
    checks++;
    if (retry_valid !== 1'b1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: valid %b empty %b, required 1 0", retry_valid, empty);
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({retry_valid, empty, nack_ready} !== 3'b010 || n_retries !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: valid %b empty %b nack_ready %b n_retries %0d, required 0 1 0 0",
               retry_valid, empty, nack_ready, n_retries);
    end
    exp_q.delete();
    rst = 1'b0;
    tick;
    do_retry(6'd5, 16);
    checks++;
    if (n_retries !== 32'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset: n_retries %0d pending %0d, required 1 0", n_retries, exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_first_retry;
    test_backoff;
    test_abort;
    test_alloc_clear;
    test_back_to_back;
    test_wrap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
